video_line_fetcher: RTL and testbench

- AXI4 burst-read engine that fills one scanline of the video controller's graphic line RAM from DRAM.
- Sits directly upstream of the pixel pipeline. The controller's clk-domain logic issues a synchronized start with source address, word count and destination offset. This block splits the transfer into legal bursts and streams the beats into the line RAM write port.

---
 rtl/video_pkg.sv | 18 +
 rtl/video_burst_calc.sv | 26 ++
 rtl/video_line_fetcher.sv | 190 +++++++++++++++++++
 tb/tb_video_line_fetcher.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video controller: fetcher FSM states, AXI burst
// constants and graphic line RAM geometry.
package video_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } fetch_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam int         AXI_4K_BYTES   = 4096;
  localparam int         WORD_BYTES     = 4;
  localparam int         LINE_WORDS     = 1024;
  localparam int         LINE_AW        = 10;

endpackage

// File: rtl/video_burst_calc.sv
// Burst sizing: beats = min(remaining, MAX_BURST, words left before the next
// 4 KB boundary); len is the AXI encoding (beats - 1).
module video_burst_calc
  import video_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic [10:0] remaining,
  input  logic [9:0]  word_lo,
  output logic [8:0]  beats,
  output logic [7:0]  len
);

  logic [10:0] room_words;
  logic [10:0] m;

  always_comb begin
    room_words = 11'(AXI_4K_BYTES / WORD_BYTES) - {1'b0, word_lo};
    m = remaining;
    if (m > 11'(MAX_BURST)) m = 11'(MAX_BURST);
    if (m > room_words) m = room_words;
    beats = m[8:0];
    len   = 8'(m - 11'd1);
  end

endmodule

// File: rtl/video_line_fetcher.sv
// AXI4 burst-read engine that fills one scanline of the graphic line RAM,
// splitting the line into 4 KB-safe bursts with one burst outstanding.
module video_line_fetcher
  import video_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BUF_AW    = 10,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [10:0]       word_count,
  input  logic [BUF_AW-1:0] dst_offset,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              err,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_waddr,
  output logic [31:0]       buf_wdata,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_payload_addr,
  output logic [7:0]        axi_ar_payload_len,
  output logic [1:0]        axi_ar_payload_burst,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [31:0]       axi_r_payload_data,
  input  logic              axi_r_payload_last
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] cur_addr, cur_addr_n;
  logic [10:0]       remaining, remaining_n, rem_after;
  logic [BUF_AW-1:0] waddr, waddr_n;
  logic [8:0]        beats_r, beats_n, bcnt, bcnt_n, bcnt_inc, calc_beats;
  logic [7:0]        calc_len;
  logic              abort_seen, abort_seen_n;
  logic              ar_valid, ar_valid_n;
  logic              done_r, done_n, overrun_r, overrun_n, err_r, err_n;
  logic              vld_p1, vld_n;
  logic [BUF_AW-1:0] waddr_p1, waddr_p1_n;
  logic [31:0]       wdata_p1, wdata_p1_n;
  logic              beat, at_count, burst_end;

  video_burst_calc #(.MAX_BURST(MAX_BURST)) u_calc (
    .remaining (remaining),
    .word_lo   (cur_addr[11:2]),
    .beats     (calc_beats),
    .len       (calc_len)
  );

  assign axi_r_ready = (state == S_DATA) || (state == S_DRAIN);
  assign beat        = axi_r_valid && axi_r_ready;
  assign bcnt_inc    = bcnt + 9'd1;
  assign at_count    = (bcnt_inc == beats_r);
  assign burst_end   = beat && (axi_r_payload_last || at_count);

  always_comb begin
    state_n      = state;
    cur_addr_n   = cur_addr;
    remaining_n  = remaining;
    waddr_n      = waddr;
    beats_n      = beats_r;
    bcnt_n       = bcnt;
    abort_seen_n = abort_seen;
    ar_valid_n   = ar_valid;
    done_n       = 1'b0;
    err_n        = err_r;
    overrun_n    = overrun_r | (start && (state != S_IDLE));
    vld_n        = 1'b0;
    waddr_p1_n   = waddr_p1;
    wdata_p1_n   = wdata_p1;
    rem_after    = remaining - 11'(beats_r);
    case (state)
      S_IDLE: begin
        if (start) begin
          cur_addr_n  = src_addr;
          remaining_n = word_count;
          waddr_n     = dst_offset;
          if (word_count == 11'd0) begin
            done_n = 1'b1;
          end else begin
            state_n      = S_ADDR;
            ar_valid_n   = 1'b1;
            abort_seen_n = 1'b0;
          end
        end
      end
      S_ADDR: begin
        // An abort here must wait for the handshake; the burst is then drained.
        abort_seen_n = abort_seen | abort;
        if (ar_valid && axi_ar_ready) begin
          ar_valid_n = 1'b0;
          beats_n    = calc_beats;
          bcnt_n     = '0;
          state_n    = (abort_seen || abort) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          bcnt_n = bcnt_inc;
          if (axi_r_payload_last != at_count) err_n = 1'b1;
        end
        if (abort) begin
          state_n = burst_end ? S_IDLE : S_DRAIN;
        end else begin
          if (beat) begin
            vld_n      = 1'b1;
            waddr_p1_n = waddr;
            wdata_p1_n = axi_r_payload_data;
            waddr_n    = waddr + BUF_AW'(1);
          end
          // Progress is accounted in whole bursts, even if r_last came early.
          if (burst_end) begin
            cur_addr_n  = cur_addr + ADDR_W'({beats_r, 2'b00});
            remaining_n = rem_after;
            if (rem_after != 11'd0) begin
              state_n      = S_ADDR;
              ar_valid_n   = 1'b1;
              abort_seen_n = 1'b0;
            end else begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (beat) begin
          bcnt_n = bcnt_inc;
          if (axi_r_payload_last != at_count) err_n = 1'b1;
        end
        if (burst_end) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      waddr      <= '0;
      beats_r    <= '0;
      bcnt       <= '0;
      abort_seen <= 1'b0;
      ar_valid   <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
      err_r      <= 1'b0;
      vld_p1     <= 1'b0;
      waddr_p1   <= '0;
      wdata_p1   <= '0;
    end else begin
      state      <= state_n;
      cur_addr   <= cur_addr_n;
      remaining  <= remaining_n;
      waddr      <= waddr_n;
      beats_r    <= beats_n;
      bcnt       <= bcnt_n;
      abort_seen <= abort_seen_n;
      ar_valid   <= ar_valid_n;
      done_r     <= done_n;
      overrun_r  <= overrun_n;
      err_r      <= err_n;
      // p1: line RAM write stage, one cycle behind the accepted beat
      vld_p1     <= vld_n;
      waddr_p1   <= waddr_p1_n;
      wdata_p1   <= wdata_p1_n;
    end
  end

  assign busy                 = (state != S_IDLE);
  assign done                 = done_r;
  assign overrun              = overrun_r;
  assign err                  = err_r;
  assign buf_we               = vld_p1;
  assign buf_waddr            = waddr_p1;
  assign buf_wdata            = wdata_p1;
  assign axi_ar_valid         = ar_valid;
  assign axi_ar_payload_addr  = cur_addr;
  assign axi_ar_payload_len   = calc_len;
  assign axi_ar_payload_burst = AXI_BURST_INCR;

endmodule

// File: tb/tb_video_line_fetcher.sv
// Scoreboard bench for video_line_fetcher: an AXI slave model with a
// synthetic DRAM, a line-level reference model and a decoupled monitor.
module tb_video_line_fetcher;

  localparam int MAXB = 64;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [31:0] src_addr;
  logic [10:0] word_count;
  logic [9:0]  dst_offset;
  logic        busy, done, overrun, err, buf_we;
  logic [9:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        axi_ar_valid, axi_ar_ready;
  logic [31:0] axi_ar_payload_addr;
  logic [7:0]  axi_ar_payload_len;
  logic [1:0]  axi_ar_payload_burst;
  logic        axi_r_valid, axi_r_ready, axi_r_payload_last;
  logic [31:0] axi_r_payload_data;

  int     checks = 0, errors = 0;
  longint cyc = 0, last_we_cyc = -1, done_cyc = -2;
  int     ndone = 0, rbeats = 0;

  logic [39:0] exp_ar[$];
  logic [41:0] exp_wr[$];
  int          exp_done = 0;
  logic [39:0] e_ar;
  logic [41:0] e_wr;

  logic [39:0] sq[$];
  logic [39:0] cur_b;
  int          bidx = 0;
  bit          stall = 0, early_en = 0, mon_en = 0;

  video_line_fetcher #(.ADDR_W(32), .BUF_AW(10), .MAX_BURST(MAXB)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .abort                (abort),
    .src_addr             (src_addr),
    .word_count           (word_count),
    .dst_offset           (dst_offset),
    .busy                 (busy),
    .done                 (done),
    .overrun              (overrun),
    .err                  (err),
    .buf_we               (buf_we),
    .buf_waddr            (buf_waddr),
    .buf_wdata            (buf_wdata),
    .axi_ar_valid         (axi_ar_valid),
    .axi_ar_ready         (axi_ar_ready),
    .axi_ar_payload_addr  (axi_ar_payload_addr),
    .axi_ar_payload_len   (axi_ar_payload_len),
    .axi_ar_payload_burst (axi_ar_payload_burst),
    .axi_r_valid          (axi_r_valid),
    .axi_r_ready          (axi_r_ready),
    .axi_r_payload_data   (axi_r_payload_data),
    .axi_r_payload_last   (axi_r_payload_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a line is cut into bursts bounded by count, MAX_BURST and 4 KB.
  task automatic model_line(input logic [31:0] src, input int cnt, input int dst);
    longint a;
    int rem, d, b, room;
    a = src; rem = cnt; d = dst;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_ar.push_back({a[31:0], 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        exp_wr.push_back({10'(d % 1024), mem_word(32'(a + 4 * i))});
        d++;
      end
      a += 4 * b;
      rem -= b;
    end
    exp_done++;
  endtask

  // AXI slave: one burst queue, data drawn from the synthetic DRAM.
  initial begin
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0;
    axi_r_payload_data = '0; axi_r_payload_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sq.delete();
        bidx = 0;
      end else begin
        if (axi_ar_valid && axi_ar_ready)
          sq.push_back({axi_ar_payload_addr, axi_ar_payload_len});
        if (axi_r_valid && axi_r_ready) begin
          rbeats++;
          if (axi_r_payload_last) begin
            void'(sq.pop_front());
            bidx = 0;
            early_en = 0;
          end else begin
            bidx++;
          end
        end
      end
      @(posedge clk); #1;
      axi_ar_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (sq.size() > 0 && (!stall || $urandom_range(0, 3) != 0)) begin
        cur_b = sq[0];
        axi_r_valid = 1'b1;
        axi_r_payload_data = mem_word(cur_b[39:8] + 32'(4 * bidx));
        axi_r_payload_last = (bidx == int'(cur_b[7:0])) || (early_en && bidx == 4);
      end else begin
        axi_r_valid = 1'b0;
        axi_r_payload_last = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (axi_ar_valid && axi_ar_ready) begin
          check("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            e_ar = exp_ar.pop_front();
            check("ar_addr", axi_ar_payload_addr, e_ar[39:8]);
            check("ar_len", axi_ar_payload_len, e_ar[7:0]);
            check("ar_burst", axi_ar_payload_burst, 1);
          end
        end
        if (buf_we) begin
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            e_wr = exp_wr.pop_front();
            check("wr_addr", buf_waddr, e_wr[41:32]);
            check("wr_data", buf_wdata, e_wr[31:0]);
          end
          last_we_cyc = cyc;
        end
        if (done) begin
          check("done_expected", exp_done != 0, 1);
          if (exp_done > 0) exp_done--;
          check("done_wr_drained", exp_wr.size(), 0);
          done_cyc = cyc;
          ndone++;
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] s, input int c, input int d);
    @(posedge clk); #1;
    src_addr = s; word_count = 11'(c); dst_offset = 10'(d); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((busy || exp_done != 0) && n < 20000);
    check({name, "_timeout"}, n < 20000, 1);
    check({name, "_ar_left"}, exp_ar.size(), 0);
    check({name, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic check_all_low(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_overrun"}, overrun, 0);
    check({name, "_err"}, err, 0);
    check({name, "_buf_we"}, buf_we, 0);
    check({name, "_ar_valid"}, axi_ar_valid, 0);
    check({name, "_r_ready"}, axi_r_ready, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, nd, c, d;
    logic [31:0] s;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; word_count = '0; dst_offset = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_low("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1;

    model_line(32'h1000_0000, 320, 0);
    pulse_start(32'h1000_0000, 320, 0);
    wait_idle("line320");
    check("line320_done_with_last_we", done_cyc - last_we_cyc, 0);

    model_line(32'h0000_0FF0, 8, 100);
    pulse_start(32'h0000_0FF0, 8, 100);
    wait_idle("cross4k");

    model_line(32'h0000_2000, 8, 1020);
    pulse_start(32'h0000_2000, 8, 1020);
    wait_idle("wrap");
    check("clean_err", err, 0);
    check("clean_overrun", overrun, 0);

    stall = 1;
    for (int t = 0; t < 8; t++) begin
      s = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(900, 1023)) << 2);
      c = (t == 0) ? 1024 : $urandom_range(1, 300);
      d = $urandom_range(0, 1023);
      model_line(s, c, d);
      pulse_start(s, c, d);
      wait_idle("rand");
    end
    stall = 0;

    nd = ndone;
    exp_done++;
    pulse_start(32'h5000_0000, 0, 7);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    repeat (5) @(posedge clk);
    #2;
    check("zero_done_once", ndone - nd, 1);
    check("zero_no_ar", exp_ar.size(), 0);

    early_en = 1;
    exp_ar.push_back({32'h3000_0FE0, 8'd7});
    exp_ar.push_back({32'h3000_1000, 8'd7});
    for (int i = 0; i < 5; i++)
      exp_wr.push_back({10'(200 + i), mem_word(32'h3000_0FE0 + 32'(4 * i))});
    for (int i = 0; i < 8; i++)
      exp_wr.push_back({10'(205 + i), mem_word(32'h3000_1000 + 32'(4 * i))});
    exp_done++;
    pulse_start(32'h3000_0FE0, 16, 200);
    wait_idle("early_last");
    check("early_last_err", err, 1);

    check("overrun_pre", overrun, 0);
    model_line(32'h2000_0100, 100, 50);
    pulse_start(32'h2000_0100, 100, 50);
    repeat (10) @(posedge clk);
    pulse_start(32'h7000_0000, 5, 0);
    @(negedge clk);
    check("overrun_set", overrun, 1);
    wait_idle("overrun");

    base = rbeats;
    nd = ndone;
    exp_ar.push_back({32'h4000_0000, 8'd63});
    for (int i = 0; i < 10; i++)
      exp_wr.push_back({10'(300 + i), mem_word(32'h4000_0000 + 32'(4 * i))});
    pulse_start(32'h4000_0000, 128, 300);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rbeats - base < 10 && n < 1000);
    abort = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (busy && n < 1000);
    check("abort_beats_at_idle", rbeats - base, 64);
    abort = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("abort_ar_left", exp_ar.size(), 0);
    check("abort_wr_left", exp_wr.size(), 0);
    check("abort_no_done", ndone - nd, 0);

    mon_en = 0;
    base = rbeats;
    pulse_start(32'h6000_0000, 64, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rbeats - base < 5 && n < 1000);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_low("midreset");
    exp_ar.delete();
    exp_wr.delete();
    exp_done = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1;

    model_line(32'h0000_0000, 40, 10);
    pulse_start(32'h0000_0000, 40, 10);
    wait_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
